// File: rtl/tinychip_pkg.sv
// Shared TinyChip definitions: fetch widths, the HALT opcode and the fetch FSM states.
package tinychip_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;
  localparam int PERF_W  = 16;

  localparam logic [INSTR_W-1:0] HALT_OPCODE = 9'h1FF;
  localparam logic [ADDR_W-1:0]  PC_LAST     = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Two saturating event counters for fetch activity; only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters
  import tinychip_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc_cycles,
  input  logic              inc_issued,
  output logic [PERF_W-1:0] cycles,
  output logic [PERF_W-1:0] issued
);

  logic [PERF_W-1:0] cycles_q, cycles_d;
  logic [PERF_W-1:0] issued_q, issued_d;

  always_comb begin
    cycles_d = cycles_q;
    issued_d = issued_q;
    if (clr) begin
      cycles_d = '0;
      issued_d = '0;
    end else begin
      if (inc_cycles && (cycles_q != '1)) cycles_d = cycles_q + 1'b1;
      if (inc_issued && (issued_q != '1)) issued_d = issued_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
      issued_q <= '0;
    end else begin
      cycles_q <= cycles_d;
      issued_q <= issued_d;
    end
  end

  assign cycles = cycles_q;
  assign issued = issued_q;

endmodule

// File: rtl/fetch_sequencer.sv
// TinyChip program counter and fetch controller with a registered valid/ready output stage.
// Define FETCH_PERF_EN to add the perf_cycles / perf_issued counter outputs.
module fetch_sequencer
  import tinychip_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               imem_done,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_cycles,
  output logic [PERF_W-1:0]  perf_issued
`endif
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  logic transfer;
  logic load_en;
  logic end_word;
  logic active;

  assign transfer = valid_q && instr_ready;
  assign load_en  = !valid_q || transfer;
  assign end_word = (imem_instr == HALT_OPCODE) || imem_done;
  assign active   = (state_q == RUN) || (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;

    // A redirect from execute overrides load, stall and end detection alike.
    if (active && branch_taken) begin
      valid_d = 1'b0;
      pc_d    = branch_target;
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_d = RUN;
            pc_d    = '0;
            valid_d = 1'b0;
          end
        end
        RUN: begin
          if (load_en) begin
            if (end_word) begin
              // The terminating word is never presented to decode.
              valid_d = 1'b0;
              state_d = DRAIN;
            end else begin
              instr_d = imem_instr;
              valid_d = 1'b1;
              if (pc_q == PC_LAST) begin
                state_d = DRAIN;
              end else begin
                pc_d = pc_q + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (load_en) begin
            valid_d = 1'b0;
            state_d = HALTED;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALTED);

`ifdef FETCH_PERF_EN
  logic perf_clr;

  assign perf_clr = start && ((state_q == IDLE) || (state_q == HALTED));

  fetch_perf_counters u_perf (
    .clk        (clk),
    .reset      (reset),
    .clr        (perf_clr),
    .inc_cycles (active),
    .inc_issued (transfer),
    .cycles     (perf_cycles),
    .issued     (perf_issued)
  );
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch controller for the TinyChip core. Drives the address of the combinational-read instruction memory, registers each 9-bit instruction into an output stage with a valid/ready handshake toward decode, redirects on taken branches, and detects end-of-program. It sits between instruction memory and decode and is the only block that sequences instruction fetch.

## Interface
- ADDR_W, 8, instruction address width (256 entries)
- INSTR_W, 9, instruction width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  pulse; begins execution at address 0 from IDLE or HALTED
- imem_addr  out  ADDR_W  address to instruction memory (equals pc)
- imem_instr  in  INSTR_W  instruction returned combinationally for imem_addr
- imem_done  in  1  memory end-of-program flag
- instr_out  out  INSTR_W  registered instruction to decode
- instr_valid  out  1  instr_out holds an unconsumed instruction
- instr_ready  in  1  decode accepts instr_out this cycle
- branch_taken  in  1  one-cycle pulse from execute: redirect fetch
- branch_target  in  ADDR_W  redirect address, valid with branch_taken
- pc  out  ADDR_W  next fetch address
- halted  out  1  program finished, output stage empty

## Operation
- States: IDLE, RUN, DRAIN, HALTED. Reset: IDLE, pc=0, instr_out=0, instr_valid=0, halted=0.
- IDLE: no fetch; start -> RUN, pc=0.
- RUN: load enabled when !instr_valid or (instr_valid && instr_ready). On load: instr_out<=imem_instr, instr_valid<=1, pc<=pc+1 (mod 256). When !load, hold everything (stall).
- End detect in RUN, on a load cycle: imem_instr == HALT_OPCODE (9'h1FF) -> do not load it, instr_valid<=0 only if current word transferring, pc holds, -> DRAIN. imem_done high -> same as HALT (word not loaded). Load from pc=255 -> word loaded, then -> DRAIN (no wrap fetch).
- DRAIN: no fetch; when !instr_valid or transfer completes -> HALTED.
- HALTED: halted=1, instr_valid=0; start -> RUN, pc=0, halted<=0.
- Branch (RUN or DRAIN): branch_taken has priority over load, stall and end-detect: instr_valid<=0 (flush, even if ready high), pc<=branch_target, state<=RUN. Ignored in IDLE/HALTED.
- start while RUN/DRAIN ignored.
- imem_done ignored outside RUN.

## Timing
- start at cycle N -> RUN at N+1 with imem_addr=0; instr_valid=1 with mem[0] at N+2, pc=1.
- Steady state with instr_ready held high: one instruction per cycle.
- instr_ready low: instr_out, instr_valid, pc held stable until accepted.
- branch_taken at N -> N+1: instr_valid=0, imem_addr=target; N+2: instr_valid=1 with mem[target]. One bubble.
- HALT word at imem_addr at cycle N with output empty -> HALTED at N+1... via DRAIN: DRAIN at N+1, halted=1 at N+2.
- reset mid-operation: all outputs return to reset values immediately (asynchronous).

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_cycles[15:0] (cycles spent in RUN/DRAIN) and perf_issued[15:0] (completed valid&&ready transfers); both saturate at 16'hFFFF, clear on reset and on accepted start.
- Undefined: ports and counters absent; other behaviour identical.

## Structure
- Shared package tinychip_pkg: ADDR_W, INSTR_W, HALT_OPCODE, fetch_state_t enum (IDLE, RUN, DRAIN, HALTED).
- One sub-module, fetch_perf_counters (two saturating 16-bit counters), instantiated only under FETCH_PERF_EN.

## Test plan
- Reset, start, mem[0..3]=9'h10F,9'h10F,9'h1AB,9'h0A9, mem[4]=9'h1FF, ready=1 -> four transfers in consecutive cycles N+2..N+5, halted=1 at N+7, pc=4.
- instr_ready low 3 cycles after first valid -> instr_out=9'h10F held, pc=1 held, then resumes with no loss/duplication.
- branch_taken with target 8'h20 while instr_valid=1, ready=0 -> next cycle instr_valid=0, imem_addr=8'h20; following cycle instr_out=mem[32].
- HALT fetched while output stalled, then branch_taken from older instruction during DRAIN -> returns to RUN at target, halted stays 0.
- No HALT in memory, straight-line run -> word at 255 issued, DRAIN, HALTED; pc does not wrap to 0.
- reset asserted mid-RUN -> instr_valid=0, pc=0, halted=0, state IDLE same cycle; start after release restarts from address 0 (perf counters 0 under FETCH_PERF_EN).
